// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 21;
    localparam int unsigned DEFAULT_DIV_VAL = 192000;
    localparam int unsigned CH_IDX_W        = 3;

    typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, double-buffered divisor, square wave and tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             pending_q,    pending_d;
    logic             clk_out_q,    clk_out_d;
    logic             tick_q,       tick_d;
    logic             terminal;
    logic             apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            div_active_q <= CNT_W'(DEFAULT_DIV);
            div_shadow_q <= '0;
            pending_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            div_shadow_q <= div_shadow_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    always_comb begin
        terminal     = (cnt_q == div_active_q);
        apply        = !en || sync || terminal;
        cnt_d        = cnt_q + CNT_W'(1);
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        div_active_d = div_active_q;
        div_shadow_d = div_shadow_q;
        pending_d    = pending_q;

        // Disable and sync both restart the phase; sync outranks terminal.
        if (!en || sync) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (terminal) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
        end

        // Apply consumes the old shadow; a same-cycle write re-arms pending.
        if (apply && pending_q) begin
            div_active_d = div_shadow_q;
            pending_d    = 1'b0;
        end
        if (wr) begin
            div_shadow_d = wdata;
            pending_d    = 1'b1;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers sharing sync and a config bus.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [NUM_CH-1:0]   pending,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel indices match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_wr && (cfg_ch == CH_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr_sel[g]),
            .wdata   (cfg_div),
            .pending (pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (NUM_CH=2, DEFAULT_DIV=4).
module tb_multi_clock_divider;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int total = 0;
    int bad   = 0;

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT, then release with the given enables; next posedge is edge 1.
    task automatic start(input logic [1:0] en_val);
        rst = 1'b1; en = 2'b00; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_div = '0;
        step();
        step();
        rst = 1'b0;
        en  = en_val;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 2'b11; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_div = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            total++;
            if ({pending, clk_out, tick} !== 6'b0) begin
                bad++;
                $display("FAIL reset n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, 6'b0);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] et;
        logic [1:0] ec;
        ec = 2'b00;
        start(2'b11);
        for (int n = 1; n <= 20; n++) begin
            step();
            et = (n % 5 == 0) ? 2'b11 : 2'b00;
            ec = ec ^ et;
            total++;
            if ({pending, clk_out, tick} !== {2'b00, ec, et}) begin
                bad++;
                $display("FAIL basic n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {2'b00, ec, et});
            end
        end
    endtask

    task automatic test_reprogram();
        logic [1:0] et;
        logic [1:0] ec;
        logic [1:0] ep;
        ec = 2'b00;
        start(2'b01);
        for (int n = 1; n <= 13; n++) begin
            cfg_wr = (n == 3); cfg_ch = 3'd0; cfg_div = 8'd1;
            step();
            cfg_wr = 1'b0;
            et = {1'b0, (n == 5) || (n >= 7 && n % 2 == 1)};
            ec = ec ^ et;
            ep = {1'b0, (n == 3) || (n == 4)};
            total++;
            if ({pending, clk_out, tick} !== {ep, ec, et}) begin
                bad++;
                $display("FAIL reprogram n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {ep, ec, et});
            end
        end
    endtask

    task automatic test_collision();
        logic [1:0] et;
        logic [1:0] ec;
        logic [1:0] ep;
        ec = 2'b00;
        start(2'b01);
        for (int n = 1; n <= 42; n++) begin
            cfg_wr  = (n == 5) || (n == 27) || (n == 28);
            cfg_ch  = 3'd0;
            cfg_div = (n == 5) ? 8'd7 : (n == 27) ? 8'd2 : 8'd3;
            step();
            cfg_wr = 1'b0;
            et = {1'b0, (n == 5) || (n == 10) || (n == 18) || (n == 26) ||
                        (n == 34) || (n == 38) || (n == 42)};
            ec = ec ^ et;
            ep = {1'b0, (n >= 5 && n <= 9) || (n >= 27 && n <= 33)};
            total++;
            if ({pending, clk_out, tick} !== {ep, ec, et}) begin
                bad++;
                $display("FAIL collision n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {ep, ec, et});
            end
        end
    endtask

    task automatic test_disable();
        logic [1:0] et;
        logic [1:0] ec;
        logic [1:0] ep;
        ec = 2'b00;
        start(2'b01);
        for (int n = 1; n <= 16; n++) begin
            en     = (n >= 8 && n <= 10) ? 2'b00 : 2'b01;
            cfg_wr = (n == 7); cfg_ch = 3'd0; cfg_div = 8'd2;
            step();
            cfg_wr = 1'b0;
            et = {1'b0, (n == 5) || (n == 13) || (n == 16)};
            ec = (en[0] == 1'b0) ? 2'b00 : (ec ^ et);
            ep = {1'b0, n == 7};
            total++;
            if ({pending, clk_out, tick} !== {ep, ec, et}) begin
                bad++;
                $display("FAIL disable n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {ep, ec, et});
            end
        end
    endtask

    task automatic test_sync();
        logic [1:0] et;
        logic [1:0] ec;
        logic [1:0] ep;
        ec = 2'b00;
        start(2'b11);
        for (int n = 1; n <= 28; n++) begin
            cfg_wr = (n == 1); cfg_ch = 3'd1; cfg_div = 8'd6;
            sync   = (n == 17) || (n == 27);
            step();
            cfg_wr = 1'b0;
            sync   = 1'b0;
            et[0] = (n == 5) || (n == 10) || (n == 15) || (n == 22);
            et[1] = (n == 5) || (n == 12) || (n == 24);
            ec = ((n == 17) || (n == 27)) ? 2'b00 : (ec ^ et);
            ep = {(n >= 1 && n <= 4), 1'b0};
            total++;
            if ({pending, clk_out, tick} !== {ep, ec, et}) begin
                bad++;
                $display("FAIL sync n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {ep, ec, et});
            end
        end
    endtask

    task automatic test_edge();
        logic [1:0] et;
        logic [1:0] ec;
        logic [1:0] ep;
        ec = 2'b00;
        start(2'b00);
        for (int n = 1; n <= 10; n++) begin
            en      = (n >= 3) ? 2'b01 : 2'b00;
            cfg_wr  = (n == 1) || (n == 6);
            cfg_ch  = (n == 6) ? 3'd5 : 3'd0;
            cfg_div = (n == 6) ? 8'd9 : 8'd0;
            step();
            cfg_wr = 1'b0;
            et = {1'b0, n >= 3};
            ec = (n >= 3) ? (ec ^ et) : 2'b00;
            ep = {1'b0, n == 1};
            total++;
            if ({pending, clk_out, tick} !== {ep, ec, et}) begin
                bad++;
                $display("FAIL edge n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {ep, ec, et});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] et;
        start(2'b11);
        for (int n = 1; n <= 6; n++) begin
            cfg_wr = (n == 5); cfg_ch = 3'd0; cfg_div = 8'd2;
            step();
            cfg_wr = 1'b0;
        end
        total++;
        if ({pending, clk_out, tick} !== 6'b01_11_00) begin
            bad++;
            $display("FAIL async_pre got=%b exp=%b", {pending, clk_out, tick}, 6'b01_11_00);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if ({pending, clk_out, tick} !== 6'b0) begin
            bad++;
            $display("FAIL async_mid got=%b exp=%b", {pending, clk_out, tick}, 6'b0);
        end
        #2 rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            et = (n == 5) ? 2'b11 : 2'b00;
            total++;
            if ({pending, clk_out, tick} !== {2'b00, et, et}) begin
                bad++;
                $display("FAIL async_post n=%0d got=%b exp=%b", n, {pending, clk_out, tick}, {2'b00, et, et});
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 2'b00; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_div = '0;
        test_reset();
        test_basic();
        test_reprogram();
        test_collision();
        test_disable();
        test_sync();
        test_edge();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
